// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one device-bus port between hosts
// Holds the selection across device stalls, supports a timed bus lock and routes read data back.
module bus_arbiter #(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int MaxLockCycles = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrHosts-1:0]              host_req_i,
  input  logic [NrHosts-1:0]              host_lock_i,
  input  logic [NrHosts-1:0]              host_we_i,
  input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]              host_gnt_o,
  output logic [NrHosts-1:0]              host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]    host_rdata_o,
  output logic                            dev_req_o,
  output logic                            dev_we_o,
  output logic [AddressWidth-1:0]         dev_addr_o,
  output logic [DataWidth-1:0]            dev_wdata_o,
  input  logic                            dev_gnt_i,
  input  logic [DataWidth-1:0]            dev_rdata_i,
  output logic                            lock_active_o
);

  localparam int PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int CntW = $clog2(MaxLockCycles + 1);

  logic [PtrW-1:0] rr_ptr;
  logic            hold_valid;
  logic [PtrW-1:0] hold_idx;
  logic            lock_active;
  logic [PtrW-1:0] lock_owner;
  logic [CntW-1:0] lock_cnt;
  logic            rpend;
  logic [PtrW-1:0] rsel;

  logic            win_valid;
  logic [PtrW-1:0] win_idx;
  int              cand;
  logic [PtrW-1:0] cand_idx;
  logic            accept;
  logic            lock_keep;
  logic            timeout;

  // Explicit wrap keeps the pointer below NrHosts for non-power-of-two host counts.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (int'(p) == NrHosts - 1) return '0;
    else return p + PtrW'(1);
  endfunction

  // Scanning downward lets the entry closest to rr_ptr overwrite the others.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (hold_valid) begin
      win_valid = 1'b1;
      win_idx   = hold_idx;
    end else if (lock_active) begin
      win_valid = host_req_i[lock_owner];
      win_idx   = lock_owner;
    end else begin
      for (int k = NrHosts - 1; k >= 0; k--) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NrHosts) cand = cand - NrHosts;
        cand_idx = PtrW'(cand);
        if (host_req_i[cand_idx]) begin
          win_valid = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  assign dev_req_o = win_valid & rst_i;
  assign accept    = dev_req_o & dev_gnt_i;

  always_comb begin
    dev_we_o    = 1'b0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    if (dev_req_o) begin
      dev_we_o    = host_we_i[win_idx];
      dev_addr_o  = host_addr_i[int'(win_idx)*AddressWidth +: AddressWidth];
      dev_wdata_o = host_wdata_i[int'(win_idx)*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    host_gnt_o = '0;
    if (accept) host_gnt_o[win_idx] = 1'b1;
  end

  always_comb begin
    host_rvalid_o = '0;
    if (rpend && rst_i) host_rvalid_o[rsel] = 1'b1;
  end

  assign host_rdata_o  = {NrHosts{dev_rdata_i}};
  assign lock_active_o = lock_active;

  // Lock state the next cycle would have if the timeout did not intervene.
  always_comb begin
    lock_keep = lock_active;
    if (accept) lock_keep = host_lock_i[win_idx];
    else if (lock_active && !hold_valid && !host_req_i[lock_owner]) lock_keep = 1'b0;
  end

  assign timeout = lock_active && lock_keep && (lock_cnt == CntW'(MaxLockCycles - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr      <= '0;
      hold_valid  <= 1'b0;
      hold_idx    <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
      lock_cnt    <= '0;
      rpend       <= 1'b0;
      rsel        <= '0;
    end else begin
      rpend <= 1'b0;
      if (dev_req_o && !dev_gnt_i) begin
        hold_valid <= 1'b1;
        hold_idx   <= win_idx;
      end
      if (accept) begin
        hold_valid <= 1'b0;
        rr_ptr     <= next_ptr(win_idx);
        rpend      <= ~host_we_i[win_idx];
        rsel       <= win_idx;
        if (host_lock_i[win_idx]) lock_owner <= win_idx;
      end
      lock_active <= lock_keep;
      lock_cnt    <= lock_active ? lock_cnt + CntW'(1) : '0;
      if (timeout) begin
        lock_active <= 1'b0;
        rr_ptr      <= next_ptr(lock_owner);
        lock_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ML = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NH-1:0]     host_req, host_lock, host_we;
  logic [NH*AW-1:0]  host_addr;
  logic [NH*DW-1:0]  host_wdata;
  logic [NH-1:0]     host_gnt, host_rvalid;
  logic [NH*DW-1:0]  host_rdata;
  logic              dev_req, dev_we, dev_gnt, lock_active;
  logic [AW-1:0]     dev_addr;
  logic [DW-1:0]     dev_wdata, dev_rdata;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxLockCycles(ML)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req), .host_lock_i(host_lock), .host_we_i(host_we),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rdata_i(dev_rdata), .lock_active_o(lock_active)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    host_req[h]            = req;
    host_we[h]             = we;
    host_lock[h]           = lock;
    host_addr[h*AW +: AW]  = addr;
    host_wdata[h*DW +: DW] = wdata;
  endtask

  initial begin
    rst_i = 1'b0; host_req = 2'b11; host_lock = '0; host_we = '0;
    host_addr = '0; host_wdata = '0; dev_gnt = 1'b1; dev_rdata = 32'hDEADBEEF;

    // reset with every host requesting
    tick(); tick(); #2;
    chk("rst_gnt", host_gnt, 0);
    chk("rst_dev_req", dev_req, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_lock", lock_active, 0);
    rst_i = 1'b1; host_req = '0; #2;
    chk("idle_dev_req", dev_req, 0);
    chk("idle_gnt", host_gnt, 0);

    // fairness: continuous reads from both hosts
    tick();
    drive(0, 1, 0, 0, 32'h1000, 0);
    drive(1, 1, 0, 0, 32'h2000, 0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("fair_gnt", host_gnt, (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("fair_addr", dev_addr, (k % 2 == 0) ? 64'h1000 : 64'h2000);
      chk("fair_rvalid", host_rvalid, (k == 0) ? 64'h0 : ((k % 2 == 1) ? 64'h1 : 64'h2));
      tick();
    end
    host_req = '0; #2;
    chk("fair_tail_gnt", host_gnt, 0);
    chk("fair_tail_rvalid", host_rvalid, 2);
    chk("fair_rdata", host_rdata, {2{32'hDEADBEEF}});
    tick(); #2;
    chk("fair_quiet_rvalid", host_rvalid, 0);

    // sticky selection across a three-cycle stall
    tick();
    dev_gnt = 1'b0;
    drive(1, 1, 0, 0, 32'h00200000, 0);
    #2;
    chk("stall0_req", dev_req, 1);
    chk("stall0_addr", dev_addr, 32'h00200000);
    chk("stall0_gnt", host_gnt, 0);
    tick();
    drive(0, 1, 0, 0, 32'h1000, 0);
    #2;
    chk("stall1_addr", dev_addr, 32'h00200000);
    chk("stall1_gnt", host_gnt, 0);
    tick(); #2;
    chk("stall2_addr", dev_addr, 32'h00200000);
    tick();
    dev_gnt = 1'b1; #2;
    chk("stall_accept_gnt", host_gnt, 2);
    chk("stall_accept_addr", dev_addr, 32'h00200000);
    tick();
    drive(1, 0, 0, 0, 0, 0); #2;
    chk("stall_next_gnt", host_gnt, 1);
    chk("stall_next_addr", dev_addr, 32'h1000);
    chk("stall_rvalid1", host_rvalid, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0); #2;
    chk("stall_rvalid0", host_rvalid, 1);

    // single host1 write brings the pointer back to host0
    tick();
    drive(1, 1, 1, 0, 32'h3000, 32'h55); #2;
    chk("wr_gnt", host_gnt, 2);
    chk("wr_we", dev_we, 1);
    chk("wr_wdata", dev_wdata, 32'h55);
    tick();
    drive(1, 0, 0, 0, 0, 0); #2;
    chk("wr_no_rvalid", host_rvalid, 0);

    // locked burst: four locked writes then an unlocking write
    tick();
    drive(1, 1, 0, 0, 32'h2000, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, (k < 4), 32'h100 + 32'(k * 4), 32'(k + 1));
      #2;
      chk("lock_gnt", host_gnt, 1);
      chk("lock_active", lock_active, (k == 0) ? 64'h0 : 64'h1);
      chk("lock_wdata", dev_wdata, 64'(k + 1));
      chk("lock_no_rvalid", host_rvalid, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0); #2;
    chk("unlock_gnt", host_gnt, 2);
    chk("unlock_active", lock_active, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0); #2;
    chk("unlock_rvalid", host_rvalid, 2);

    // lock timeout after MaxLockCycles locked cycles
    tick();
    drive(1, 1, 0, 0, 32'h2000, 0);
    drive(0, 1, 1, 1, 32'h400, 32'hA5);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("tmo_gnt", host_gnt, 1);
      chk("tmo_active", lock_active, (k == 0) ? 64'h0 : 64'h1);
      tick();
    end
    #2;
    chk("tmo_release_gnt", host_gnt, 2);
    chk("tmo_release_active", lock_active, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); #2;
    chk("tmo_rvalid", host_rvalid, 2);

    // owner dropping its request releases the lock
    tick();
    drive(1, 1, 0, 0, 32'h2000, 0);
    drive(0, 1, 1, 1, 32'h500, 32'h77); #2;
    chk("drop_first_gnt", host_gnt, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0); #2;
    chk("drop_locked", lock_active, 1);
    chk("drop_dev_req", dev_req, 0);
    chk("drop_gnt", host_gnt, 0);
    tick(); #2;
    chk("drop_released", lock_active, 0);
    chk("drop_gnt_other", host_gnt, 2);

    // reset in the cycle after an accepted read
    tick();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h600, 0); #2;
    chk("mid_read_gnt", host_gnt, 1);
    tick();
    rst_i = 1'b0;
    drive(1, 1, 0, 0, 32'h2000, 0); #2;
    chk("mid_rst_rvalid", host_rvalid, 0);
    chk("mid_rst_gnt", host_gnt, 0);
    chk("mid_rst_dev_req", dev_req, 0);
    tick(); #2;
    chk("mid_rst_gnt2", host_gnt, 0);
    rst_i = 1'b1; #2;
    chk("restart_gnt", host_gnt, 1);
    chk("restart_addr", dev_addr, 32'h600);
    tick();
    host_req = '0;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one downstream device-bus port between NrHosts requesters, e.g. the core data port plus a DMA or debug host.
- Sits between the hosts and the existing address-decoding bus. The downstream port uses the same req/gnt/addr/we/wdata/rdata protocol as a single host.
- Adds sticky selection across device stalls, optional bus locking with a timeout, and one-cycle read-data return routing.

Parameters:
- NrHosts, 2, number of requesting hosts (>=2).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxLockCycles, 16, maximum consecutive cycles one host may hold the lock before a forced release (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- host_req_i  in  NrHosts  per-host request; held with its fields until granted.
- host_lock_i  in  NrHosts  per-host lock request, sampled on the accepted transfer.
- host_we_i  in  NrHosts  per-host write enable.
- host_addr_i  in  NrHosts*AddressWidth  packed addresses; host i at [i*AW +: AW].
- host_wdata_i  in  NrHosts*DataWidth  packed write data.
- host_gnt_o  out  NrHosts  one-hot grant; the transfer is accepted in this cycle.
- host_rvalid_o  out  NrHosts  one-hot read-data-valid, one cycle after a read grant.
- host_rdata_o  out  NrHosts*DataWidth  dev_rdata_i broadcast to every slot.
- dev_req_o  out  1  downstream request.
- dev_we_o  out  1  downstream write enable.
- dev_addr_o  out  AddressWidth  downstream address.
- dev_wdata_o  out  DataWidth  downstream write data.
- dev_gnt_i  in  1  downstream accepts the transfer this cycle.
- dev_rdata_i  in  DataWidth  downstream read data, valid the cycle after a read accept.
- lock_active_o  out  1  lock currently held.

Behaviour:
- State:
  - rr_ptr: priority pointer, clog2(NrHosts) bits.
  - hold_valid / hold_idx: sticky selection.
  - lock_active / lock_owner.
  - lock_cnt: clog2(MaxLockCycles+1) bits.
  - rpend / rsel: pending read return.
- Reset (rst_i=0, asynchronous):
  - All state registers clear to 0.
  - host_gnt_o, host_rvalid_o, dev_req_o and lock_active_o are forced to 0 while reset is asserted.
- Winner selection, evaluated in this priority order:
  - if hold_valid: winner = hold_idx;
  - else if lock_active: winner = lock_owner, eligible only if host_req_i[lock_owner]=1;
  - else: the first i with host_req_i[i]=1, searching from rr_ptr upward with wrap to 0.
- Downstream drive:
  - dev_req_o = 1 when a winner exists.
  - dev_we_o, dev_addr_o and dev_wdata_o are muxed combinationally from the winner.
  - When no winner exists, these fields are driven to 0.
- Grant: host_gnt_o[winner] = dev_req_o & dev_gnt_i; all other grant bits are 0.
- Stall (dev_req_o=1, dev_gnt_i=0):
  - hold_valid<=1 and hold_idx<=winner.
  - The selection cannot change until accepted, even if a higher-priority host raises its request.
- Accepted transfer (dev_req_o & dev_gnt_i), at the clock edge:
  - hold_valid<=0.
  - rr_ptr <= (winner+1) mod NrHosts.
  - rpend <= ~we and rsel <= winner.
  - If host_lock_i[winner]=1: lock_active<=1 and lock_owner<=winner.
  - If host_lock_i[winner]=0: lock_active<=0.
- No accept this cycle: rpend<=0.
- Read return: host_rvalid_o[rsel] = rpend. Writes never produce rvalid. Back-to-back reads pipeline with one read return per cycle.
- Lock release:
  - Cleared by an accepted transfer from the owner with host_lock_i=0.
  - Cleared by owner host_req_i=0 in any cycle while locked and not held.
- Lock timeout:
  - lock_cnt increments each cycle lock_active=1 and clears when lock_active=0.
  - When lock_cnt = MaxLockCycles-1 and the lock would remain: force lock_active<=0, rr_ptr<=lock_owner+1, lock_cnt<=0.
  - A held (stalled) transfer still completes before any other host is granted.
- Simultaneous events:
  - A timeout and an accepted owner transfer with lock_i=1 in the same cycle resolve as: timeout wins, lock cleared.
  - Reset mid-transaction drops the pending rvalid; no grant is issued during reset.
- NrHosts not a power of two: the wrap is explicit, so rr_ptr never holds a value >= NrHosts.

Test Plan:
- Reset: rst_i=0 with all host_req_i=1 -> host_gnt_o=0, dev_req_o=0, host_rvalid_o=0. After release with host_req_i=0 -> dev_req_o=0.
- Fairness: NrHosts=2, both hosts issue continuous reads, dev_gnt_i=1 -> grants alternate 0,1,0,1. host_rvalid_o[i]=1 exactly one cycle after each gnt[i], carrying dev_rdata_i (e.g. 0xDEADBEEF).
- Sticky stall: host1 requests a read at 0x00200000 with dev_gnt_i=0 for 3 cycles; host0 (rr_ptr=0) requests from cycle 2 -> dev_addr_o stays 0x00200000. When dev_gnt_i=1, gnt[1] fires first, then gnt[0].
- Lock: host0 issues 4 writes with lock_i=1 then 1 with lock_i=0; host1 requests throughout -> 5 consecutive gnt[0], then gnt[1]. No rvalid for the writes.
- Timeout: MaxLockCycles=4, host0 keeps req=1 and lock=1 while host1 requests -> lock_active_o drops after 4 locked cycles and the next grant goes to host1.
- Reset mid-read: read accepted, then rst_i=0 in the following cycle -> host_rvalid_o stays 0 and no grant is issued. After release, arbitration restarts at host0.
